// File: rtl/sonic_echo_emu_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : sonic_echo_emu_if
// Purpose  : trig/echo pin bundle between a ranging front end and the
//            sonic_echo_emu responder (pin-for-pin with an HC-SR04).
// Signals  : trig       front end -> emulator, asynchronous trigger
//            dist_cm    front end -> emulator, programmed distance (cm)
//            echo       emulator -> front end, echo pulse
//            busy       emulator -> front end, measurement in progress
//            short_trig emulator -> front end, rejected short trigger pulse
//            echo_done  emulator -> front end, echo falling-edge pulse
// Modports : master = ranging front end, slave = emulator
// Revision : 1.0 - initial release
// ============================================================================
interface sonic_echo_emu_if;
  logic       trig;
  logic [9:0] dist_cm;
  logic       echo;
  logic       busy;
  logic       short_trig;
  logic       echo_done;

  modport master (
    output trig, dist_cm,
    input  echo, busy, short_trig, echo_done
  );

  modport slave (
    input  trig, dist_cm,
    output echo, busy, short_trig, echo_done
  );
endinterface
`default_nettype wire

// File: rtl/sonic_echo_emu.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : sonic_echo_emu
// Purpose  : Cycle-accurate HC-SR04 responder. Watches trig and answers with
//            an echo pulse whose width encodes a programmed distance.
// Ports    : clk50  in   system clock, rising edge
//            rst_n  in   asynchronous active-low reset
//            bus    slave modport of sonic_echo_emu_if
//                   (trig, dist_cm in; echo, busy, short_trig, echo_done out)
// Options  : SONIC_EMU_TIMEOUT_EN - when defined, distances above MAX_CM give
//            the no-object echo of TIMEOUT_CYC cycles; otherwise they
//            saturate to MAX_CM.
// Revision : 1.0 - initial release
// ============================================================================
module sonic_echo_emu #(
  parameter int TRIG_MIN_CYC = 500,
  parameter int HOLDOFF_CYC  = 25000,
  parameter int CYC_PER_CM   = 2900,
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_CYC  = 1900000,
  parameter int RECOVER_CYC  = 500000
) (
  input  logic                   clk50,
  input  logic                   rst_n,
  sonic_echo_emu_if.slave        bus
);

  localparam logic [20:0] C_TRIG_MIN = 21'(TRIG_MIN_CYC);
  localparam logic [20:0] C_HOLD_M1  = 21'(HOLDOFF_CYC - 1);
  localparam logic [20:0] C_REC_M1   = 21'(RECOVER_CYC - 1);
  localparam logic [20:0] C_CPC      = 21'(CYC_PER_CM);
  localparam logic [20:0] C_MAX_N    = 21'(MAX_CM * CYC_PER_CM);
  localparam logic [9:0]  C_MAX_CM   = 10'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_HOLDOFF = 3'd2,
    S_ECHO    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, trig_s_q, trig_prev_q;
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] n_q, n_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        short_q, short_d;
  logic        done_q, done_d;

  logic        trig_rise;
  logic [9:0]  dist_eff;
  logic [20:0] n_calc;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer plus a delayed copy for edge detection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      sync1_q     <= bus.trig;
      trig_s_q    <= sync1_q;
      trig_prev_q <= trig_s_q;
    end
  end

  assign trig_rise = trig_s_q & ~trig_prev_q;

  // --------------------------------------------------------------------------
  // Echo width from the live distance; only captured at latch time
  // --------------------------------------------------------------------------
  always_comb begin
    dist_eff = (bus.dist_cm == 10'd0) ? 10'd1 : bus.dist_cm;
    n_calc   = 21'(dist_eff) * C_CPC;
    if (bus.dist_cm > C_MAX_CM) begin
`ifdef SONIC_EMU_TIMEOUT_EN
      n_calc = 21'(TIMEOUT_CYC);
`else
      n_calc = C_MAX_N;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State register and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      short_q <= short_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A single 21-bit counter serves every phase: it counts
  // up while trig is high and down (terminal value 0) in the timed phases.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    short_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          state_d = S_TRIG_HI;
          cnt_d   = '0;
        end
      end

      S_TRIG_HI: begin
        // TRIG_HI is only entered with trig_s high and left on its first
        // low cycle, so a low trig_s here is always the falling edge.
        if (trig_s_q) begin
          if (cnt_q < C_TRIG_MIN) begin
            cnt_d = cnt_q + 21'd1;
          end
        end else if (cnt_q >= C_TRIG_MIN) begin
          n_d     = n_calc;
          cnt_d   = C_HOLD_M1;
          state_d = S_HOLDOFF;
        end else begin
          short_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_HOLDOFF: begin
        if (cnt_q == '0) begin
          cnt_d   = n_q - 21'd1;
          state_d = S_ECHO;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end

      S_ECHO: begin
        if (cnt_q == '0) begin
          cnt_d   = C_REC_M1;
          done_d  = 1'b1;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end

      S_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of the next state so echo and busy
    // change on the same edge as the state they describe.
    echo_d = (state_d == S_ECHO);
    busy_d = (state_d == S_HOLDOFF) || (state_d == S_ECHO) ||
             (state_d == S_RECOVER);
  end

  assign bus.echo       = echo_q;
  assign bus.busy       = busy_q;
  assign bus.short_trig = short_q;
  assign bus.echo_done  = done_q;

endmodule
`default_nettype wire
